// File: rtl/cu_command_arbiter_rr.sv
// Round-robin arbiter sharing one downstream command buffer between NUM_REQ requester FIFOs.
// Define CU_CMD_ARB_STATS_EN to build the grant/stall statistics counters.
package cu_command_arbiter_rr_pkg;
    typedef struct packed {
        logic        valid;
        logic [3:0]  opcode;
        logic [31:0] address;
        logic [7:0]  tag;
    } CommandBufferLine;

    typedef struct packed {
        logic alempty;
        logic empty;
        logic alfull;
        logic full;
    } BufferStatus;
endpackage

module cu_command_arbiter_rr
    import cu_command_arbiter_rr_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clock,
    input  logic                 rstn,
    input  logic                 arbiter_enabled_in,
    input  CommandBufferLine     requester_command_in [NUM_REQ],
    input  BufferStatus          command_buffer_status,
    output BufferStatus          requester_buffer_status_out [NUM_REQ],
    output CommandBufferLine     command_arbiter_out,
    output logic [NUM_REQ-1:0]   command_arbiter_grant_out,
    output logic [NUM_REQ-1:0]   overflow_error_out,
    output logic [31:0]          grant_count_out [NUM_REQ],
    output logic [31:0]          stall_count_out
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ALFULL_CNT = CNT_W'(FIFO_DEPTH - 3);

    CommandBufferLine   in_q     [NUM_REQ];
    CommandBufferLine   in_d     [NUM_REQ];
    CommandBufferLine   mem_q    [NUM_REQ][FIFO_DEPTH];
    CommandBufferLine   mem_d    [NUM_REQ][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_REQ];
    logic [PTR_W-1:0]   wr_ptr_d [NUM_REQ];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_REQ];
    logic [PTR_W-1:0]   rd_ptr_d [NUM_REQ];
    logic [CNT_W-1:0]   cnt_q    [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d    [NUM_REQ];
    BufferStatus        status_q [NUM_REQ];
    BufferStatus        status_d [NUM_REQ];
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] overflow_q, overflow_d;
    CommandBufferLine   out_q, out_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic [NUM_REQ-1:0] eligible, push, pop;
    logic [IDX_W-1:0]   winner, cand;
    logic               found, grant_en;
    logic               unused_status;

    assign unused_status = ^{command_buffer_status.alempty, command_buffer_status.empty,
                             command_buffer_status.full};

    // Search starts at rr_ptr and wraps; first non-empty FIFO wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = (cnt_q[i] != '0);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        grant_en = arbiter_enabled_in && !command_buffer_status.alfull && found;

        rr_ptr_d = rr_ptr_q;
        out_d    = '0;
        grant_d  = '0;
        if (grant_en) begin
            rr_ptr_d       = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
            out_d          = mem_q[winner][rd_ptr_q[winner]];
            out_d.valid    = 1'b1;
            grant_d[winner] = 1'b1;
        end
    end

    // Inputs are registered first; full is judged on the count before this edge.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            in_d[i]       = requester_command_in[i];
            push[i]       = in_q[i].valid && (cnt_q[i] != FULL_CNT);
            pop[i]        = grant_en && (winner == IDX_W'(i));
            overflow_d[i] = overflow_q[i] | (in_q[i].valid && (cnt_q[i] == FULL_CNT));
            wr_ptr_d[i]   = wr_ptr_q[i];
            rd_ptr_d[i]   = rd_ptr_q[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_q[i];
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            cnt_d[i]           = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            status_d[i]        = '0;
            status_d[i].empty  = (cnt_q[i] == '0);
            status_d[i].alfull = (cnt_q[i] >= ALFULL_CNT);
            status_d[i].full   = (cnt_q[i] == FULL_CNT);
        end
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                in_q[i]           <= '0;
                wr_ptr_q[i]       <= '0;
                rd_ptr_q[i]       <= '0;
                cnt_q[i]          <= '0;
                status_q[i]       <= '0;
                status_q[i].empty <= 1'b1;
            end
            rr_ptr_q   <= '0;
            overflow_q <= '0;
            out_q      <= '0;
            grant_q    <= '0;
        end else begin
            in_q       <= in_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
            out_q      <= out_d;
            grant_q    <= grant_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counts alone.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign requester_buffer_status_out = status_q;
    assign command_arbiter_out         = out_q;
    assign command_arbiter_grant_out   = grant_q;
    assign overflow_error_out          = overflow_q;

`ifdef CU_CMD_ARB_STATS_EN
    logic [31:0] grant_cnt_q [NUM_REQ];
    logic [31:0] grant_cnt_d [NUM_REQ];
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i] + 32'(pop[i]);
        end
        stall_cnt_d = stall_cnt_q
                    + 32'(|eligible && arbiter_enabled_in && command_buffer_status.alfull);
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_count_out = grant_cnt_q;
    assign stall_count_out = stall_cnt_q;
`else
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_count_out[i] = '0;
        end
    end
    assign stall_count_out = '0;
`endif

endmodule

// File: tb/tb_cu_command_arbiter_rr.sv
// Scenario bench for cu_command_arbiter_rr: per-feature tasks plus an output scoreboard.
module tb_cu_command_arbiter_rr;
    import cu_command_arbiter_rr_pkg::*;

    localparam int NUM_REQ    = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int CW         = $bits(CommandBufferLine);

    logic               clock = 1'b0;
    logic               rstn;
    logic               arbiter_enabled_in;
    CommandBufferLine   cmd_in [NUM_REQ];
    BufferStatus        ds_status;
    BufferStatus        req_status [NUM_REQ];
    CommandBufferLine   cmd_out;
    logic [NUM_REQ-1:0] grant_out;
    logic [NUM_REQ-1:0] overflow_out;
    logic [31:0]        grant_count [NUM_REQ];
    logic [31:0]        stall_count;

    logic [CW-1:0]      exp_q [$];
    logic [NUM_REQ-1:0] exp_g_q [$];
    int                 n_checks = 0;
    int                 n_fail   = 0;
    int                 out_seen = 0;

    cu_command_arbiter_rr #(.NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock                       (clock),
        .rstn                        (rstn),
        .arbiter_enabled_in          (arbiter_enabled_in),
        .requester_command_in        (cmd_in),
        .command_buffer_status       (ds_status),
        .requester_buffer_status_out (req_status),
        .command_arbiter_out         (cmd_out),
        .command_arbiter_grant_out   (grant_out),
        .overflow_error_out          (overflow_out),
        .grant_count_out             (grant_count),
        .stall_count_out             (stall_count)
    );

    always #5 clock = ~clock;

    // Scoreboard: every valid output must match the oldest expected command.
    always @(negedge clock) begin
        logic [CW-1:0]      e_c;
        logic [NUM_REQ-1:0] e_g;
        if (rstn && cmd_out.valid) begin
            out_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got cmd %h grant %b, required no output", cmd_out, grant_out);
            end else begin
                e_c = exp_q.pop_front();
                e_g = exp_g_q.pop_front();
                if (cmd_out !== e_c || grant_out !== e_g) begin
                    n_fail++;
                    $display("FAIL out_data: got cmd %h grant %b, required cmd %h grant %b", cmd_out, grant_out, e_c, e_g);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM_REQ; i++) cmd_in[i] = '0;
    endtask

    task automatic drive(input logic [NUM_REQ-1:0] mask, input bit expect_out);
        CommandBufferLine c;
        for (int i = 0; i < NUM_REQ; i++) begin
            cmd_in[i] = '0;
            if (mask[i]) begin
                c.valid   = 1'b1;
                c.opcode  = 4'($urandom_range(0, 15));
                c.address = $urandom();
                c.tag     = 8'($urandom_range(0, 255));
                cmd_in[i] = c;
                if (expect_out) begin
                    exp_q.push_back(c);
                    exp_g_q.push_back(NUM_REQ'(1) << i);
                end
            end
        end
    endtask

    task automatic test_reset();
        BufferStatus st;
        st       = '0;
        st.empty = 1'b1;
        rstn = 1'b0;
        tick();
        tick();
        n_checks++;
        if (cmd_out !== '0 || grant_out !== '0 || overflow_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cmd %h grant %b ovf %b, required all 0", cmd_out, grant_out, overflow_out);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            n_checks++;
            if (req_status[i] !== st || grant_count[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_status[%0d]: got status %b count %0d, required %b 0", i, req_status[i], grant_count[i], st);
            end
        end
        n_checks++;
        if (stall_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stall: got %0d, required 0", stall_count);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic               exp_v;
        logic [NUM_REQ-1:0] exp_g;
        for (int cyc = 0; cyc < 11; cyc++) begin
            if (cyc < 4) drive(2'b11, 1'b1);
            tick();
            exp_v = (cyc >= 2 && cyc <= 9);
            exp_g = !exp_v ? 2'b00 : ((cyc % 2 == 0) ? 2'b01 : 2'b10);
            n_checks++;
            if (cmd_out.valid !== exp_v || grant_out !== exp_g) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got valid %b grant %b, required valid %b grant %b", cyc, cmd_out.valid, grant_out, exp_v, exp_g);
            end
        end
`ifdef CU_CMD_ARB_STATS_EN
        n_checks++;
        if (grant_count[0] !== 32'd4 || grant_count[1] !== 32'd4) begin
            n_fail++;
            $display("FAIL b2b_grant_count: got {%0d,%0d}, required {4,4}", grant_count[0], grant_count[1]);
        end
`else
        n_checks++;
        if (grant_count[0] !== 32'd0 || grant_count[1] !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_grant_count_off: got {%0d,%0d}, required {0,0}", grant_count[0], grant_count[1]);
        end
`endif
    endtask

    task automatic test_single_requester();
        logic               exp_v;
        logic [NUM_REQ-1:0] exp_g;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc < 3) drive(2'b10, 1'b1);
            tick();
            exp_v = (cyc >= 2 && cyc <= 4);
            exp_g = exp_v ? 2'b10 : 2'b00;
            n_checks++;
            if (cmd_out.valid !== exp_v || grant_out !== exp_g) begin
                n_fail++;
                $display("FAIL single_cycle%0d: got valid %b grant %b, required valid %b grant %b", cyc, cmd_out.valid, grant_out, exp_v, exp_g);
            end
        end
        // Pointer should be back at 0: a simultaneous pair must come out requester 0 first.
        drive(2'b11, 1'b1);
        for (int k = 0; k < 5; k++) tick();
    endtask

    task automatic test_backpressure();
        int base;
        base = out_seen;
        for (int cyc = 0; cyc < 11; cyc++) begin
            if (cyc < 5) drive(2'b01, 1'b1);
            ds_status.alfull = (cyc >= 1);
            tick();
            n_checks++;
            if (cmd_out.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_cycle%0d: got valid %b, required 0", cyc, cmd_out.valid);
            end
        end
        ds_status.alfull = 1'b0;
`ifdef CU_CMD_ARB_STATS_EN
        n_checks++;
        if (stall_count !== 32'd9) begin
            n_fail++;
            $display("FAIL bp_stall_count: got %0d, required 9", stall_count);
        end
`endif
        for (int k = 0; k < 10; k++) tick();
        n_checks++;
        if (out_seen - base != 5) begin
            n_fail++;
            $display("FAIL bp_release_outputs: got %0d, required 5", out_seen - base);
        end
    endtask

    task automatic test_overflow();
        int base;
        arbiter_enabled_in = 1'b0;
        for (int k = 0; k < 4; k++) begin drive(2'b01, 1'b1); tick(); end
        for (int k = 0; k < 3; k++) tick();
        n_checks++;
        if (req_status[0].alfull !== 1'b0 || req_status[0].empty !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_count4_status: got %b, required empty 0 alfull 0", req_status[0]);
        end
        drive(2'b01, 1'b1); tick();
        for (int k = 0; k < 3; k++) tick();
        n_checks++;
        if (req_status[0].alfull !== 1'b1 || req_status[0].full !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_count5_status: got %b, required alfull 1 full 0", req_status[0]);
        end
        for (int k = 0; k < 3; k++) begin drive(2'b01, 1'b1); tick(); end
        for (int k = 0; k < 3; k++) tick();
        n_checks++;
        if (req_status[0].full !== 1'b1 || overflow_out !== 2'b00) begin
            n_fail++;
            $display("FAIL ovf_count8_status: got %b ovf %b, required full 1 ovf 00", req_status[0], overflow_out);
        end
        drive(2'b01, 1'b0); tick();
        for (int k = 0; k < 3; k++) tick();
        n_checks++;
        if (overflow_out !== 2'b01) begin
            n_fail++;
            $display("FAIL ovf_flag: got %b, required 01", overflow_out);
        end
        base = out_seen;
        arbiter_enabled_in = 1'b1;
        for (int k = 0; k < 14; k++) tick();
        n_checks++;
        if (out_seen - base != 8 || req_status[0].empty !== 1'b1 || overflow_out !== 2'b01) begin
            n_fail++;
            $display("FAIL ovf_drain: got %0d outputs empty %b ovf %b, required 8 1 01", out_seen - base, req_status[0].empty, overflow_out);
        end
    endtask

    task automatic test_disable_gating();
        int base;
        base = out_seen;
        for (int k = 0; k < 3; k++) begin drive(2'b01, 1'b1); tick(); end
        arbiter_enabled_in = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (cmd_out.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL gate_hold%0d: got valid %b, required 0", k, cmd_out.valid);
            end
        end
        n_checks++;
        if (out_seen - base != 1) begin
            n_fail++;
            $display("FAIL gate_inflight: got %0d outputs, required 1", out_seen - base);
        end
        arbiter_enabled_in = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        n_checks++;
        if (out_seen - base != 3) begin
            n_fail++;
            $display("FAIL gate_resume: got %0d outputs, required 3", out_seen - base);
        end
    endtask

    task automatic test_reset_midstream();
        int          base;
        BufferStatus st;
        st       = '0;
        st.empty = 1'b1;
        for (int k = 0; k < 3; k++) begin drive(2'b11, 1'b1); tick(); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        n_checks++;
        if (cmd_out !== '0 || grant_out !== '0 || overflow_out !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got cmd %h grant %b ovf %b, required all 0", cmd_out, grant_out, overflow_out);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            n_checks++;
            if (req_status[i] !== st || grant_count[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL midrst_status[%0d]: got %b count %0d, required %b 0", i, req_status[i], grant_count[i], st);
            end
        end
        exp_q.delete();
        exp_g_q.delete();
        base = out_seen;
        for (int k = 0; k < 12; k++) tick();
        n_checks++;
        if (out_seen != base) begin
            n_fail++;
            $display("FAIL midrst_stale: got %0d outputs, required 0", out_seen - base);
        end
    endtask

    initial begin
        rstn               = 1'b0;
        arbiter_enabled_in = 1'b1;
        ds_status          = '0;
        for (int i = 0; i < NUM_REQ; i++) cmd_in[i] = '0;
        test_reset();
        test_back_to_back();
        test_single_requester();
        test_backpressure();
        test_overflow();
        test_disable_gating();
        test_reset_midstream();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
